// File: rtl/crc5_pkg.sv
// crc5_pkg: shared CRC-5 constants, FSM states and the single LFSR step used by both link ends.
package crc5_pkg;
    localparam int CRC_WIDTH = 5;
    localparam logic [CRC_WIDTH-1:0] CRC_POLY = 5'b01001;
    localparam logic [CRC_WIDTH-1:0] CRC_INIT_DEFAULT = 5'b00000;

    typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK, DONE} state_t;

    function automatic logic [CRC_WIDTH-1:0] crc_step(logic [CRC_WIDTH-1:0] s, logic d);
        return {s[CRC_WIDTH-2:0], 1'b0} ^ ((d ^ s[CRC_WIDTH-1]) ? CRC_POLY : '0);
    endfunction
endpackage

// File: rtl/crc5_frame_checker_if.sv
// crc5_frame_checker_if: serial frame input and check results between link and checker.
interface crc5_frame_checker_if #(parameter int PAYLOAD_LEN = 5);
    logic start;
    logic data_valid;
    logic data;
    logic busy;
    logic done;
    logic crc_ok;
    logic crc_err;
    logic [PAYLOAD_LEN-1:0] payload;
    logic [crc5_pkg::CRC_WIDTH-1:0] remainder;

    modport master (output start, data_valid, data,
                    input busy, done, crc_ok, crc_err, payload, remainder);
    modport slave (input start, data_valid, data,
                   output busy, done, crc_ok, crc_err, payload, remainder);
endinterface

// File: rtl/crc5_lfsr.sv
// crc5_lfsr: MSB-first CRC-5 LFSR register with load and per-bit step.
module crc5_lfsr
    import crc5_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [CRC_WIDTH-1:0] init,
    input  logic                 step,
    input  logic                 din,
    output logic [CRC_WIDTH-1:0] state
);
    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= init;
        else if (load) state <= init;
        else if (step) state <= crc_step(state, din);
endmodule

// File: rtl/crc5_frame_checker.sv
// crc5_frame_checker: captures a serial payload, runs CRC-5 over payload+CRC and flags a zero residue.
module crc5_frame_checker
    import crc5_pkg::*;
#(
    parameter int                   PAYLOAD_LEN = 5,
    parameter logic [CRC_WIDTH-1:0] INIT        = CRC_INIT_DEFAULT
) (
    input logic clk,
    input logic reset,
    crc5_frame_checker_if.slave bus
);
    localparam int CW = $clog2(PAYLOAD_LEN + 1) < 3 ? 3 : $clog2(PAYLOAD_LEN + 1);

    state_t st;
    logic [CW-1:0] cnt;
    logic [CRC_WIDTH-1:0] lfsr;
    logic take;

    // start always wins over a coincident data bit
    assign take = bus.data_valid && !bus.start && (st == PAYLOAD || st == CHECK);

    crc5_lfsr u_lfsr (
        .clk   (clk),
        .reset (reset),
        .load  (bus.start),
        .init  (INIT),
        .step  (take),
        .din   (bus.data),
        .state (lfsr)
    );

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            st <= IDLE;
            cnt <= '0;
            bus.payload <= '0;
            bus.remainder <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.crc_ok <= 1'b0;
            bus.crc_err <= 1'b0;
        end else if (bus.start) begin
            st <= PAYLOAD;
            cnt <= '0;
            bus.payload <= '0;
            bus.busy <= 1'b1;
            bus.done <= 1'b0;
            bus.crc_ok <= 1'b0;
            bus.crc_err <= 1'b0;
        end else begin
            bus.done <= (st == DONE);
            if (st == DONE) begin
                bus.remainder <= lfsr;
                bus.crc_ok <= (lfsr == '0);
                bus.crc_err <= (lfsr != '0);
                st <= IDLE;
            end else if (take) begin
                if (st == PAYLOAD) bus.payload <= PAYLOAD_LEN'({bus.payload, bus.data});
                if (st == PAYLOAD && cnt == CW'(PAYLOAD_LEN - 1)) begin
                    st <= CHECK;
                    cnt <= '0;
                end else if (st == CHECK && cnt == CW'(CRC_WIDTH - 1)) begin
                    st <= DONE;
                    cnt <= '0;
                    bus.busy <= 1'b0;
                end else cnt <= cnt + 1'b1;
            end
        end
endmodule

// File: tb/tb_crc5_frame_checker.sv
// tb_crc5_frame_checker: directed and random frames checked against a polynomial-division CRC model.
module tb_crc5_frame_checker;
    localparam int L = 5;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    crc5_frame_checker_if #(.PAYLOAD_LEN(L)) bus();
    crc5_frame_checker #(.PAYLOAD_LEN(L)) dut (.clk(clk), .reset(reset), .bus(bus));

    int vectors = 0;
    int miscompares = 0;

    // remainder of an n-bit GF(2) polynomial divided by x^5+x^3+1
    function automatic logic [4:0] pmod(logic [127:0] v, int n);
        logic [5:0] r = '0;
        for (int i = n - 1; i >= 0; i--) begin
            r = {r[4:0], v[i]};
            if (r[5]) r = r ^ 6'b101001;
        end
        return r[4:0];
    endfunction

    function automatic logic [4:0] gen_crc(logic [L-1:0] p);
        return pmod(128'(p) << 5, L + 5);
    endfunction

    function automatic logic [4:0] residue(logic [L-1:0] p, logic [4:0] c);
        return pmod(128'({p, c}) << 5, L + 10);
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(logic s, logic v, logic d);
        bus.start = s;
        bus.data_valid = v;
        bus.data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_ok"}, bus.crc_ok, 0);
        chk({tag, "_err"}, bus.crc_err, 0);
        chk({tag, "_payload"}, bus.payload, 0);
        chk({tag, "_rem"}, bus.remainder, 0);
    endtask

    // mode 0: back-to-back, 1: gaps cycling 1/3/7, 2: random gaps 0..4
    task automatic send_bits(logic [L-1:0] p, logic [4:0] c, int mode);
        logic [L+4:0] f = {p, c};
        int g;
        for (int i = L + 4; i >= 0; i--) begin
            cyc(1'b0, 1'b1, f[i]);
            chk("busy_bit", bus.busy, 64'(i != 0));
            chk("early_done", bus.done, 0);
            g = mode == 1 ? (i % 3 == 0 ? 1 : i % 3 == 1 ? 3 : 7) :
                mode == 2 ? int'($urandom_range(0, 4)) : 0;
            if (i != 0)
                repeat (g) begin
                    cyc(1'b0, 1'b0, 1'($urandom));
                    chk("busy_gap", bus.busy, 1);
                end
        end
    endtask

    task automatic finish_frame(logic [L-1:0] p, logic [4:0] c);
        logic [4:0] r = residue(p, c);
        chk("done_latency", bus.done, 0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("done", bus.done, 1);
        chk("crc_ok", bus.crc_ok, 64'(r == 0));
        chk("crc_err", bus.crc_err, 64'(r != 0));
        chk("remainder", bus.remainder, r);
        chk("payload", bus.payload, p);
        cyc(1'b0, 1'b1, 1'($urandom));
        chk("done_pulse", bus.done, 0);
        chk("crc_ok_held", bus.crc_ok, 64'(r == 0));
        chk("payload_held", bus.payload, p);
    endtask

    task automatic frame(logic [L-1:0] p, logic [4:0] c, int mode);
        cyc(1'b1, 1'b0, 1'b0);
        send_bits(p, c, mode);
        finish_frame(p, c);
    endtask

    initial begin
        logic [L-1:0] p;
        logic [4:0] c;
        logic [9:0] bits;
        bus.start = 1'b0;
        bus.data_valid = 1'b0;
        bus.data = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        reset = 1'b1;
        cyc(1'b0, 1'b1, 1'b1);
        chk("idle_ignore", bus.busy, 0);

        frame(5'b10101, 5'b11001, 0);
        chk("good_ok", bus.crc_ok, 1);
        frame(5'b10101, 5'b11000, 0);
        chk("bad_rem", bus.remainder, 5'b01001);
        frame(5'b10101, 5'b11001, 1);

        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        frame(5'b10101, 5'b11001, 0);

        cyc(1'b1, 1'b1, 1'b0);
        send_bits(5'b10101, 5'b11001, 0);
        finish_frame(5'b10101, 5'b11001);

        cyc(1'b1, 1'b0, 1'b0);
        send_bits(5'b01110, 5'b00000, 0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("abort_done", bus.done, 0);
        chk("abort_ok", bus.crc_ok, 0);
        chk("abort_busy", bus.busy, 1);
        send_bits(5'b10101, 5'b11001, 0);
        finish_frame(5'b10101, 5'b11001);

        cyc(1'b1, 1'b0, 1'b0);
        bits = 10'b1010111001;
        for (int i = 9; i >= 3; i--) cyc(1'b0, 1'b1, bits[i]);
        reset = 1'b0;
        #1;
        chk_zero("midreset");
        @(posedge clk);
        #1;
        chk("midreset_nodone", bus.done, 0);
        reset = 1'b1;
        frame(5'b10101, 5'b11001, 0);

        for (int k = 0; k < 40; k++) begin
            p = L'($urandom);
            c = $urandom_range(0, 1) ? gen_crc(p) : 5'($urandom);
            frame(p, c, 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/crc5_frame_checker.md
Name: crc5_frame_checker

Overview:
- Serial receive-side partner of the team's CRC-5 generator (polynomial x^5+x^3+1, taps 5'b01001, MSB-first, no reflection, no final XOR).
- Accepts a framed bit stream of PAYLOAD_LEN payload bits followed by 5 CRC bits.
- Captures the payload, runs the identical LFSR over payload+CRC, and flags pass/fail from a zero residue.
- Sits after the serial link, in front of payload consumers.

Parameters:
PAYLOAD_LEN, 5, payload bits per frame (1..64)
INIT, 5'b00000, LFSR value loaded on start (must match the generator's init)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  1-cycle pulse: begin a new frame, aborts any frame in progress
data_valid  input  1  data bit is presented this cycle
data  input  1  serial bit, payload MSB first, then CRC MSB first
busy  output  1  frame in progress (PAYLOAD or CHECK state)
done  output  1  1-cycle pulse: frame complete, results valid
crc_ok  output  1  last frame residue == 0; held until next start/reset
crc_err  output  1  last frame residue != 0; held until next start/reset
payload  output  PAYLOAD_LEN  captured payload, first bit at MSB; held after done
remainder  output  5  LFSR residue after last CRC bit; held after done

Behaviour:
- Reset (reset=0, async): state IDLE, LFSR=INIT, bit counter=0, payload=0, remainder=0, busy=0, done=0, crc_ok=0, crc_err=0.
- LFSR step on each accepted bit: x = data ^ lfsr[4]; lfsr <= {lfsr[3], lfsr[2]^x, lfsr[1], lfsr[0], x}.
- States:
  - IDLE: start -> PAYLOAD; LFSR<=INIT, counter<=0, crc_ok/crc_err<=0, payload<=0.
  - PAYLOAD: each data_valid=1 cycle shifts data into payload LSB and steps the LFSR. After PAYLOAD_LEN accepted bits -> CHECK, counter<=0.
  - CHECK: each data_valid=1 cycle steps the LFSR only; payload is frozen. After 5 accepted bits -> DONE.
  - DONE (1 cycle): done=1; remainder<=lfsr; crc_ok<=(lfsr==0); crc_err<=(lfsr!=0); -> IDLE.
- Stalls: data_valid=0 holds all state; gaps of any length are legal.
- Latency: done rises on the clock edge after the edge that accepts the 5th CRC bit.
- start while busy or in DONE: abort the current frame and restart as from IDLE. No done pulse for the aborted frame; crc_ok/crc_err cleared.
- start together with data_valid: start wins and the data bit is ignored (the first bit is taken the next cycle).
- data_valid in IDLE without start: ignored.
- busy = (state==PAYLOAD || state==CHECK).
- crc_ok and crc_err are mutually exclusive and never both 1.
- Reset mid-frame: immediate return to reset values; no done pulse.
- Counter width: $clog2(PAYLOAD_LEN+1), minimum 3 bits, so it can count the 5 CRC bits.

Decomposition:
- Package crc5_pkg: CRC_WIDTH=5, CRC_POLY=5'b01001, CRC_INIT_DEFAULT=5'b00000, state enum {IDLE, PAYLOAD, CHECK, DONE}.
- Sub-module crc5_lfsr (ports: clk, reset, load, init, step, din, state). This is the single LFSR step, shared with the generator so both ends use the same taps.

Test Plan:
- Good frame: reset release; start; bits 10101 then CRC 11001, one bit per cycle -> done pulse one cycle after the last bit; crc_ok=1, crc_err=0, remainder=00000, payload=10101.
- Corrupt frame: same payload, CRC 11000 -> crc_err=1, crc_ok=0, remainder=01001, payload=10101.
- Stalled stream: good frame with data_valid=0 inserted for 1, 3 and 7 cycles between bits -> identical results to the good frame; busy stays 1 throughout the gaps.
- Restart: start, send 101, pulse start again, then send the full good frame -> a single done pulse, crc_ok=1, payload=10101.
- Start with valid: start and data_valid=1 in the same cycle with data=0, then the good frame -> crc_ok=1 (the collided bit is ignored).
- Reset mid-frame: drive reset=0 after 7 accepted bits -> all outputs 0 immediately with no clock edge needed; after release, a good frame passes with crc_ok=1.
